step_pulse_gen: RTL and testbench



---
 rtl/semicpu_pkg.sv | 14 +
 rtl/sync_2ff.sv | 21 ++
 rtl/step_pulse_gen.sv | 134 +++++++++++++
 tb/tb_step_pulse_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/semicpu_pkg.sv
// Shared SemiCPU definitions: step pulse generator state encoding and display widths.
package semicpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_t;

  localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a slow asynchronous level (buttons), synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s
);

  logic q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      q1 <= d;
      s  <= q1;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Turns the raw CONTROL push-button into a clean one-cycle STEP strobe for the program
// counter, with optional hold-to-repeat. DEBOUNCE_CYCLES must be >= 2.
module step_pulse_gen
  import semicpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 20000000,
  parameter int CNT_W           = 26
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BTN_IN,
  input  logic                  REPEAT_EN,
  output logic                  STEP,
  output logic                  BTN_LEVEL,
  output logic [STEP_CNT_W-1:0] STEP_COUNT,
  output logic [2:0]            state_dbg
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             step_nxt;
  logic             level_nxt;
  logic             s;

  sync_2ff u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (BTN_IN),
    .s   (s)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      STEP       <= 1'b0;
      BTN_LEVEL  <= 1'b0;
      STEP_COUNT <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      STEP      <= step_nxt;
      BTN_LEVEL <= level_nxt;
      if (step_nxt) STEP_COUNT <= STEP_COUNT + 1'b1;
    end
  end

  // Release (s low) always outranks timer expiry, so a letting-go edge never steps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = 1'b0;
    level_nxt = BTN_LEVEL;
    case (state)
      ST_IDLE: begin
        level_nxt = 1'b0;
        if (s) begin
          state_nxt = ST_PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          step_nxt  = 1'b1;
          level_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (!REPEAT_EN) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_REPEAT;
          cnt_nxt   = '0;
          step_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (!s) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (!REPEAT_EN) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt  = '0;
          step_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_RELEASE_DB: begin
        if (s) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen with short debounce/hold/repeat timings.
module tb_step_pulse_gen;
  import semicpu_pkg::*;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  // Drive cycle to STEP cycle: 1 to first sample, 2 sync, then IDLE edge + DB counting edges.
  localparam int LAT  = DB + 3;

  logic       clk = 1'b0;
  logic       RESET;
  logic       BTN_IN;
  logic       REPEAT_EN;
  logic       STEP;
  logic       BTN_LEVEL;
  logic [7:0] STEP_COUNT;
  logic [2:0] state_dbg;

  logic [31:0] cyc = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_count = 0;
  int          n_total = 0;
  int          n_pass = 0;

  step_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP),
    .CNT_W           (26)
  ) dut (
    .CLK        (clk),
    .RESET      (RESET),
    .BTN_IN     (BTN_IN),
    .REPEAT_EN  (REPEAT_EN),
    .STEP       (STEP),
    .BTN_LEVEL  (BTN_LEVEL),
    .STEP_COUNT (STEP_COUNT),
    .state_dbg  (state_dbg)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every STEP must match the oldest expected cycle stamp
  always @(negedge clk) begin
    logic [31:0] e;
    if (STEP === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL step_unexpected: STEP high at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e !== cyc) $display("FAIL step_time: STEP at cycle %0d, expected cycle %0d", cyc, e);
        else n_pass++;
      end
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      n_total++;
      e = exp_q.pop_front();
      $display("FAIL step_missing: no STEP at cycle %0d (STEP=%b), expected one", e, STEP);
    end
  end

  // driver tasks
  task automatic at_cyc(input logic [31:0] t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic press_release();
    logic [31:0] n;
    int h;
    n = cyc;
    h = $urandom_range(8, 14);
    BTN_IN = 1'b1;
    exp_q.push_back(n + LAT);
    exp_count++;
    at_cyc(n + h);
    BTN_IN = 1'b0;
    at_cyc(n + h + LAT + 1);
  endtask

  // scenarios
  task automatic test_reset();
    RESET = 1'b1;
    BTN_IN = 1'b0;
    REPEAT_EN = 1'b0;
    at_cyc(3);
    n_total++; if (STEP !== 1'b0) $display("FAIL rst_step: got %b want 0", STEP); else n_pass++;
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL rst_level: got %b want 0", BTN_LEVEL); else n_pass++;
    n_total++; if (STEP_COUNT !== 8'd0) $display("FAIL rst_count: got %0d want 0", STEP_COUNT); else n_pass++;
    n_total++; if (state_dbg !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    RESET = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_clean_press();
    logic [31:0] n, m;
    n = cyc;
    BTN_IN = 1'b1;
    exp_q.push_back(n + LAT);
    exp_count++;
    at_cyc(n + LAT - 1);
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL clean_level_early: got %b want 0", BTN_LEVEL); else n_pass++;
    at_cyc(n + LAT);
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL clean_count: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
    n_total++; if (BTN_LEVEL !== 1'b1) $display("FAIL clean_level_hi: got %b want 1", BTN_LEVEL); else n_pass++;
    at_cyc(n + 40);
    m = cyc;
    BTN_IN = 1'b0;
    at_cyc(m + LAT - 1);
    n_total++; if (BTN_LEVEL !== 1'b1) $display("FAIL clean_release_early: got %b want 1", BTN_LEVEL); else n_pass++;
    at_cyc(m + LAT);
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL clean_release: got %b want 0", BTN_LEVEL); else n_pass++;
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL clean_count_end: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
  endtask

  task automatic test_bouncy_press();
    logic [31:0] n, m;
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      BTN_IN = (i % 2 == 0);
      at_cyc(n + 2 * (i + 1));
    end
    m = cyc;
    BTN_IN = 1'b1;
    exp_q.push_back(m + LAT);
    exp_count++;
    at_cyc(m + LAT - 1);
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL bounce_level_early: got %b want 0", BTN_LEVEL); else n_pass++;
    at_cyc(m + LAT);
    n_total++; if (BTN_LEVEL !== 1'b1) $display("FAIL bounce_level_hi: got %b want 1", BTN_LEVEL); else n_pass++;
    at_cyc(m + 20);
    m = cyc;
    BTN_IN = 1'b0;
    at_cyc(m + LAT + 1);
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL bounce_count: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
  endtask

  task automatic test_bouncy_release();
    logic [31:0] n, m;
    n = cyc;
    BTN_IN = 1'b1;
    exp_q.push_back(n + LAT);
    exp_count++;
    at_cyc(n + 20);
    for (int g = 0; g < 2; g++) begin
      BTN_IN = 1'b0;
      at_cyc(cyc + 3);
      BTN_IN = 1'b1;
      at_cyc(cyc + 5);
      n_total++; if (BTN_LEVEL !== 1'b1) $display("FAIL glitch_level: glitch %0d got %b want 1", g, BTN_LEVEL); else n_pass++;
    end
    m = cyc;
    BTN_IN = 1'b0;
    at_cyc(m + LAT - 1);
    n_total++; if (BTN_LEVEL !== 1'b1) $display("FAIL glitch_release_early: got %b want 1", BTN_LEVEL); else n_pass++;
    at_cyc(m + LAT);
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL glitch_release: got %b want 0", BTN_LEVEL); else n_pass++;
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL glitch_count: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
  endtask

  task automatic test_auto_repeat();
    logic [31:0] n, m;
    REPEAT_EN = 1'b1;
    n = cyc;
    BTN_IN = 1'b1;
    exp_q.push_back(n + LAT);
    exp_q.push_back(n + LAT + HOLD);
    for (int k = 1; k <= 3; k++) exp_q.push_back(n + LAT + HOLD + k * REP);
    exp_count += 5;
    at_cyc(n + LAT + HOLD + 3 * REP + 2);
    REPEAT_EN = 1'b0;
    at_cyc(n + 60);
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL repeat_count: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
    n_total++; if (state_dbg !== ST_HELD) $display("FAIL repeat_stop_state: got %0d want %0d", state_dbg, ST_HELD); else n_pass++;
    m = cyc;
    BTN_IN = 1'b0;
    at_cyc(m + LAT);
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL repeat_release: got %b want 0", BTN_LEVEL); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] n;
    // release lands on the same edge as the hold expiry
    REPEAT_EN = 1'b1;
    n = cyc;
    BTN_IN = 1'b1;
    exp_q.push_back(n + LAT);
    exp_count++;
    at_cyc(n + LAT + HOLD - 3);
    BTN_IN = 1'b0;
    at_cyc(n + LAT + HOLD + 3);
    n_total++; if (BTN_LEVEL !== 1'b1) $display("FAIL race_rel_level: got %b want 1", BTN_LEVEL); else n_pass++;
    at_cyc(n + LAT + HOLD + 4);
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL race_rel_idle: got %b want 0", BTN_LEVEL); else n_pass++;
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL race_rel_count: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
    at_cyc(cyc + 2);
    // REPEAT_EN drop lands on the same edge as the repeat expiry
    n = cyc;
    BTN_IN = 1'b1;
    exp_q.push_back(n + LAT);
    exp_q.push_back(n + LAT + HOLD);
    exp_count += 2;
    at_cyc(n + LAT + HOLD + REP - 1);
    REPEAT_EN = 1'b0;
    at_cyc(n + 40);
    n_total++; if (state_dbg !== ST_HELD) $display("FAIL race_en_state: got %0d want %0d", state_dbg, ST_HELD); else n_pass++;
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL race_en_count: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
    n = cyc;
    BTN_IN = 1'b0;
    at_cyc(n + LAT + 1);
  endtask

  task automatic test_reset_mid_press();
    logic [31:0] n;
    n = cyc;
    BTN_IN = 1'b1;
    at_cyc(n + 4);
    n_total++; if (state_dbg !== ST_PRESS_DB) $display("FAIL midrst_pre_state: got %0d want %0d", state_dbg, ST_PRESS_DB); else n_pass++;
    RESET = 1'b1;
    at_cyc(n + 5);
    exp_count = 0;
    n_total++; if (STEP !== 1'b0) $display("FAIL midrst_step: got %b want 0", STEP); else n_pass++;
    n_total++; if (BTN_LEVEL !== 1'b0) $display("FAIL midrst_level: got %b want 0", BTN_LEVEL); else n_pass++;
    n_total++; if (STEP_COUNT !== 8'd0) $display("FAIL midrst_count: got %0d want 0", STEP_COUNT); else n_pass++;
    n_total++; if (state_dbg !== ST_IDLE) $display("FAIL midrst_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    at_cyc(n + 6);
    RESET = 1'b0;
    exp_q.push_back(n + 6 + LAT);
    exp_count++;
    at_cyc(n + 6 + LAT);
    n_total++; if (STEP_COUNT !== exp_count) $display("FAIL midrst_restep: got %0d want %0d", STEP_COUNT, exp_count); else n_pass++;
    n = cyc;
    BTN_IN = 1'b0;
    at_cyc(n + LAT + 1);
  endtask

  task automatic test_wrap();
    while (exp_count != 8'd255) press_release();
    n_total++; if (STEP_COUNT !== 8'd255) $display("FAIL wrap_255: got %0d want 255", STEP_COUNT); else n_pass++;
    press_release();
    n_total++; if (STEP_COUNT !== 8'd0) $display("FAIL wrap_0: got %0d want 0", STEP_COUNT); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_bouncy_release();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_press();
    test_wrap();
    at_cyc(cyc + 20);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL pending_steps: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    n_total++;
    $display("FAIL timeout: simulation still running at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
